// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared address width and state encoding for banked_ram
package ram_pkg;

  localparam int ADDR_W = 15;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/dualportram.sv
// rtl/dualportram.sv - one-write/one-read synchronous RAM, read-before-write
module dualportram #(
  parameter int ADDRBITS = 9,
  parameter int DATABITS = 8
) (
  input  logic                clk,
  input  logic                write_en,
  input  logic [ADDRBITS-1:0] write_addr,
  input  logic [DATABITS-1:0] write_data,
  input  logic [ADDRBITS-1:0] read_addr,
  output logic [DATABITS-1:0] read_data
);

  logic [DATABITS-1:0] mem [1 << ADDRBITS];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/banked_ram.sv
// rtl/banked_ram.sv - two-lane windowed RAM with post-reset clear
// Optional RAM_BYPASS_EN: same-address read-during-write returns the new data.
module banked_ram
  import ram_pkg::*;
#(
  parameter int          ADDRBITS = 10,
  parameter logic [15:0] TOP      = 16'h4000,
  parameter int          DATABITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   read_addr_even,
  input  logic [ADDR_W-1:0]   write_addr_even,
  input  logic [DATABITS-1:0] write_data_even,
  input  logic                write_en_even,
  input  logic [ADDR_W-1:0]   read_addr_odd,
  input  logic [ADDR_W-1:0]   write_addr_odd,
  input  logic [DATABITS-1:0] write_data_odd,
  input  logic                write_en_odd,
  output logic [DATABITS-1:0] read_data_even,
  output logic                read_hit_even,
  output logic [DATABITS-1:0] read_data_odd,
  output logic                read_hit_odd,
  output logic                busy
);

  localparam int LW   = ADDRBITS - 1;
  localparam int SIZE = 1 << ADDRBITS;
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W + 1)'((int'(TOP) - SIZE) / 2);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W + 1)'(int'(TOP) / 2);

  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  function automatic logic [LW-1:0] local_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] d;
    d = a - WIN_LO[ADDR_W-1:0];
    return d[LW-1:0];
  endfunction

  state_t        state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    if (state == CLEAR) begin
      busy    = 1'b1;
      cnt_nxt = cnt + 1'b1;
      if (cnt == {LW{1'b1}}) state_nxt = READY;
    end
  end

  logic [ADDR_W-1:0]   raddr [2];
  logic [ADDR_W-1:0]   waddr [2];
  logic [DATABITS-1:0] wdata [2];
  logic [DATABITS-1:0] rdata [2];
  logic                wen   [2];
  logic                rhit  [2];

  assign raddr[0] = read_addr_even;
  assign raddr[1] = read_addr_odd;
  assign waddr[0] = write_addr_even;
  assign waddr[1] = write_addr_odd;
  assign wdata[0] = write_data_even;
  assign wdata[1] = write_data_odd;
  assign wen[0]   = write_en_even;
  assign wen[1]   = write_en_odd;

  assign read_data_even = rdata[0];
  assign read_data_odd  = rdata[1];
  assign read_hit_even  = rhit[0];
  assign read_hit_odd   = rhit[1];

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic                r_in, we, hit_q, valid_q;
    logic [LW-1:0]       ra, wa;
    logic [DATABITS-1:0] wd, ram_q;

    // While clearing, the port is owned by the clear counter and user writes are dropped.
    assign r_in = in_win(raddr[l]);
    assign ra   = local_addr(raddr[l]);
    assign we   = busy | (wen[l] & in_win(waddr[l]));
    assign wa   = busy ? cnt : local_addr(waddr[l]);
    assign wd   = busy ? '0 : wdata[l];

    dualportram #(
      .ADDRBITS(LW),
      .DATABITS(DATABITS)
    ) u_ram (
      .clk       (clk),
      .write_en  (we),
      .write_addr(wa),
      .write_data(wd),
      .read_addr (ra),
      .read_data (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hit_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        hit_q   <= r_in;
        valid_q <= r_in & ~busy;
      end
    end

`ifdef RAM_BYPASS_EN
    logic                byp_q;
    logic [DATABITS-1:0] byp_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        byp_q <= 1'b0;
        byp_d <= '0;
      end else begin
        byp_q <= we & ~busy & (wa == ra);
        byp_d <= wd;
      end
    end

    assign rdata[l] = !valid_q ? '0 : (byp_q ? byp_d : ram_q);
`else
    assign rdata[l] = valid_q ? ram_q : '0;
`endif
    assign rhit[l] = hit_q;
  end

endmodule

// File: tb/tb_banked_ram.sv
// tb/tb_banked_ram.sv - vector table and scoreboard bench for banked_ram
module tb_banked_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] read_addr_even = '0, write_addr_even = '0;
  logic [14:0] read_addr_odd = '0, write_addr_odd = '0;
  logic [7:0]  write_data_even = '0, write_data_odd = '0;
  logic        write_en_even = 1'b0, write_en_odd = 1'b0;
  logic [7:0]  read_data_even, read_data_odd;
  logic        read_hit_even, read_hit_odd, busy;

  always #5 clk = ~clk;

  banked_ram #(.ADDRBITS(10), .TOP(16'h4000), .DATABITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .read_addr_even (read_addr_even),
    .write_addr_even(write_addr_even),
    .write_data_even(write_data_even),
    .write_en_even  (write_en_even),
    .read_addr_odd  (read_addr_odd),
    .write_addr_odd (write_addr_odd),
    .write_data_odd (write_data_odd),
    .write_en_odd   (write_en_odd),
    .read_data_even (read_data_even),
    .read_hit_even  (read_hit_even),
    .read_data_odd  (read_data_odd),
    .read_hit_odd   (read_hit_odd),
    .busy           (busy)
  );

`ifdef RAM_BYPASS_EN
  localparam logic [7:0] RAW_EXP = 8'h3c;
`else
  localparam logic [7:0] RAW_EXP = 8'h11;
`endif

  typedef struct {
    string       name;
    logic        we_e;
    logic [14:0] wa_e;
    logic [7:0]  wd_e;
    logic        we_o;
    logic [14:0] wa_o;
    logic [7:0]  wd_o;
    logic [14:0] ra_e;
    logic [14:0] ra_o;
    logic [7:0]  xd_e;
    logic        xh_e;
    logic [7:0]  xd_o;
    logic        xh_o;
    logic        xbusy;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] d_e;
    logic       h_e;
    logic [7:0] d_o;
    logic       h_o;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  vec_t main_vecs[12];
  vec_t post_vecs[2];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(string nm, logic we_e, logic [14:0] wa_e, logic [7:0] wd_e,
                               logic we_o, logic [14:0] wa_o, logic [7:0] wd_o,
                               logic [14:0] ra_e, logic [14:0] ra_o,
                               logic [7:0] xd_e, logic xh_e, logic [7:0] xd_o, logic xh_o,
                               logic xbusy);
    vec_t v;
    v.name = nm; v.we_e = we_e; v.wa_e = wa_e; v.wd_e = wd_e;
    v.we_o = we_o; v.wa_o = wa_o; v.wd_o = wd_o; v.ra_e = ra_e; v.ra_o = ra_o;
    v.xd_e = xd_e; v.xh_e = xh_e; v.xd_o = xd_o; v.xh_o = xh_o; v.xbusy = xbusy;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    write_en_even = 1'b0;
    write_en_odd  = 1'b0;
  endtask

  task automatic drive_step(input vec_t v);
    exp_t e;
    write_en_even   = v.we_e; write_addr_even = v.wa_e; write_data_even = v.wd_e;
    write_en_odd    = v.we_o; write_addr_odd  = v.wa_o; write_data_odd  = v.wd_o;
    read_addr_even  = v.ra_e; read_addr_odd   = v.ra_o;
    e.name = v.name; e.d_e = v.xd_e; e.h_e = v.xh_e; e.d_o = v.xd_o; e.h_o = v.xh_o;
    e.busy = v.xbusy;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    e = sb.pop_front();
    check({e.name, ".data_even"}, int'(read_data_even), int'(e.d_e));
    check({e.name, ".hit_even"},  int'(read_hit_even),  int'(e.h_e));
    check({e.name, ".data_odd"},  int'(read_data_odd),  int'(e.d_o));
    check({e.name, ".hit_odd"},   int'(read_hit_odd),   int'(e.h_o));
    check({e.name, ".busy"},      int'(busy),           int'(e.busy));
  endtask

  // Counts edges until busy falls; a pollution write may be fired at a given edge index.
  task automatic count_clear(input string nm, input int poke_at);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      if (n == poke_at) begin
        write_en_even = 1'b1; write_addr_even = 15'h1e20; write_data_even = 8'h99;
        write_en_odd  = 1'b1; write_addr_odd  = 15'h1e20; write_data_odd  = 8'h99;
      end else begin
        idle_inputs();
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    idle_inputs();
    check(nm, n, 512);
  endtask

  initial begin
    main_vecs[0]  = mkv("clr_read",  0, 0, 0, 0, 0, 0, 15'h1e05, 15'h1e05, 8'h00, 1, 8'h00, 1, 0);
    main_vecs[1]  = mkv("wr_lanes",  1, 15'h1e10, 8'ha5, 1, 15'h1e10, 8'h5a, 15'h1e20, 15'h1e20, 8'h00, 1, 8'h00, 1, 0);
    main_vecs[2]  = mkv("rd_lanes",  0, 0, 0, 0, 0, 0, 15'h1e10, 15'h1e10, 8'ha5, 1, 8'h5a, 1, 0);
    main_vecs[3]  = mkv("wr_below",  1, 15'h1dff, 8'h77, 0, 0, 0, 15'h1dff, 15'h1fff, 8'h00, 0, 8'h00, 1, 0);
    main_vecs[4]  = mkv("rd_below",  0, 0, 0, 0, 0, 0, 15'h1dff, 15'h1e10, 8'h00, 0, 8'h5a, 1, 0);
    main_vecs[5]  = mkv("wr_edges",  1, 15'h1fff, 8'h42, 1, 15'h1e00, 8'h24, 15'h1e10, 15'h1dff, 8'ha5, 1, 8'h00, 0, 0);
    main_vecs[6]  = mkv("rd_edges",  0, 0, 0, 0, 0, 0, 15'h1fff, 15'h1e00, 8'h42, 1, 8'h24, 1, 0);
    main_vecs[7]  = mkv("wr_above",  1, 15'h2000, 8'h55, 1, 15'h1f00, 8'h11, 15'h2000, 15'h0000, 8'h00, 0, 8'h00, 0, 0);
    main_vecs[8]  = mkv("wr_11",     1, 15'h1f00, 8'h11, 0, 0, 0, 15'h1fff, 15'h1f00, 8'h42, 1, 8'h11, 1, 0);
    main_vecs[9]  = mkv("no_alias",  0, 0, 0, 0, 0, 0, 15'h1e00, 15'h1fff, 8'h00, 1, 8'h00, 1, 0);
    main_vecs[10] = mkv("raw",       1, 15'h1f00, 8'h3c, 0, 0, 0, 15'h1f00, 15'h1f00, RAW_EXP, 1, 8'h11, 1, 0);
    main_vecs[11] = mkv("after_raw", 0, 0, 0, 0, 0, 0, 15'h1f00, 15'h1e00, 8'h3c, 1, 8'h24, 1, 0);
    post_vecs[0]  = mkv("rst_lost",  0, 0, 0, 0, 0, 0, 15'h1e20, 15'h1e20, 8'h00, 1, 8'h00, 1, 0);
    post_vecs[1]  = mkv("rst_wiped", 0, 0, 0, 0, 0, 0, 15'h1e10, 15'h1f00, 8'h00, 1, 8'h00, 1, 0);

    read_addr_even = 15'h1e05;
    read_addr_odd  = 15'h1e05;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", int'(busy), 1);
    check("rst.data_even", int'(read_data_even), 0);
    check("rst.hit_even", int'(read_hit_even), 0);
    check("rst.data_odd", int'(read_data_odd), 0);
    check("rst.hit_odd", int'(read_hit_odd), 0);

    reset = 1'b0;
    count_clear("clear_len", 300);

    for (int i = 0; i < 12; i++) drive_step(main_vecs[i]);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) begin
      @(posedge clk);
      @(negedge clk);
    end
    drive_step(mkv("busy_rd", 1, 15'h1e20, 8'h99, 1, 15'h1e20, 8'h99, 15'h1e20, 15'h1e20, 8'h00, 1, 8'h00, 1, 1));
    repeat (49) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    #2;
    check("mid_rst.busy", int'(busy), 1);
    check("mid_rst.hit_even", int'(read_hit_even), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_clear("reclear_len", -1);

    for (int i = 0; i < 2; i++) drive_step(post_vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
